// File: rtl/lfsr6s3_checker_if.sv
// lfsr6s3_checker_if: bus between a PRBS word source and the LFSR checker.
//   en       word valid strobe (source -> checker)
//   x[5:0]   received word, bits [6:1] of the generator (source -> checker)
//   clr      clear of the error counter (source -> checker)
//   locked   checker is in SYNC (checker -> source)
//   bit_err  one-cycle pulse, last checked word had bit errors (checker -> source)
//   err_cnt  saturating bit-error count (checker -> source)
//   lockup   one-cycle pulse, all-ones word seen while hunting (checker -> source)
interface lfsr6s3_checker_if #(
  parameter int ERRW = 16
) ();
  logic            en;
  logic [5:0]      x;
  logic            clr;
  logic            locked;
  logic            bit_err;
  logic [ERRW-1:0] err_cnt;
  logic            lockup;

  modport master (
    output en, x, clr,
    input  locked, bit_err, err_cnt, lockup
  );

  modport slave (
    input  en, x, clr,
    output locked, bit_err, err_cnt, lockup
  );
endinterface

// File: rtl/lfsr6s3_checker.sv
// lfsr6s3_checker: receive-side checker for the three-step length-6 XNOR LFSR.
// Hunts for the sequence by re-seeding its prediction from every received
// word, locks after LOCK_CNT consecutive correct predictions, then flywheels
// its own prediction and counts bit errors until LOSS_CNT consecutive bad
// words drop it back to hunting.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    lfsr6s3_checker_if slave (en, x, clr in; locked, bit_err,
//          err_cnt, lockup out)
//
// state | meaning
// HUNT  | searching; prediction re-seeded from every received word
// SYNC  | locked; prediction runs free, mismatches counted as errors
module lfsr6s3_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERRW     = 16
) (
  input  logic                clk,
  input  logic                reset,
  lfsr6s3_checker_if.slave    bus
);

  typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} state_t;

  localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

  state_t          state_q, state_d;
  logic [5:0]      p_q, p_d;
  logic            have_prev_q, have_prev_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            bit_err_q, bit_err_d;
  logic            lockup_q, lockup_d;

  logic [5:0]      pred;
  logic [5:0]      err_vec;
  logic [2:0]      nerr;
  logic            match;
  logic            is_lockup;
  logic [3:0]      cnt_inc;
  logic [ERRW:0]   err_sum;
  logic [ERRW-1:0] err_sat;

  // Three generator steps folded into one word: x[5] is bit 6, x[0] is bit 1.
  function automatic logic [5:0] step(input logic [5:0] w);
    step = {w[2], w[1], w[0], ~(w[4] ^ w[5]), ~(w[3] ^ w[4]), ~(w[2] ^ w[3])};
  endfunction

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  always_comb begin
    pred      = step(p_q);
    err_vec   = bus.x ^ pred;
    nerr      = popcount6(err_vec);
    match     = (nerr == 3'd0);
    is_lockup = (bus.x == 6'h3F);
    cnt_inc   = cnt_q + 4'd1;
    err_sum   = {1'b0, err_cnt_q} + (ERRW+1)'(nerr);
    err_sat   = err_sum[ERRW] ? ERR_MAX : err_sum[ERRW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    have_prev_d = have_prev_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    bit_err_d   = 1'b0;
    lockup_d    = 1'b0;

    if (bus.en) begin
      case (state_q)
        HUNT: begin
          p_d      = bus.x;
          lockup_d = is_lockup;
          if (!have_prev_q) begin
            have_prev_d = 1'b1;
            cnt_d       = 4'd0;
          end else if (match && !is_lockup) begin
            // step(0x3F) = 0x3F, so the lockup word must never count as a match
            if (cnt_inc == 4'(LOCK_CNT)) begin
              state_d = SYNC;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        SYNC: begin
          p_d = pred;
          if (match) begin
            cnt_d = 4'd0;
          end else begin
            bit_err_d = 1'b1;
            err_cnt_d = err_sat;
            if (cnt_inc == 4'(LOSS_CNT)) begin
              state_d     = HUNT;
              cnt_d       = 4'd0;
              have_prev_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (bus.clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      p_q         <= 6'h00;
      have_prev_q <= 1'b0;
      cnt_q       <= 4'd0;
      err_cnt_q   <= '0;
      bit_err_q   <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      have_prev_q <= have_prev_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      bit_err_q   <= bit_err_d;
      lockup_q    <= lockup_d;
    end
  end

  assign bus.locked  = (state_q == SYNC);
  assign bus.bit_err = bit_err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr6s3_checker.sv
// tb_lfsr6s3_checker: directed bench for lfsr6s3_checker. One instance with
// ERRW=16 covers lock, flywheel, loss/relock, en gaps, lockup, clr and reset;
// a second with ERRW=4 covers counter saturation.
module tb_lfsr6s3_checker;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [5:0] w;

  always #5 clk = ~clk;

  lfsr6s3_checker_if #(.ERRW(16)) b16 ();
  lfsr6s3_checker_if #(.ERRW(4))  b4 ();

  lfsr6s3_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERRW(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  lfsr6s3_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERRW(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  // Stimulus generator: the true transmitted sequence.
  function automatic logic [5:0] nxt(input logic [5:0] v);
    nxt = {v[2], v[1], v[0], ~(v[4] ^ v[5]), ~(v[3] ^ v[4]), ~(v[2] ^ v[3])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic e, input logic [5:0] v, input logic c);
    b16.en = e; b16.x = v; b16.clr = c;
    tick();
  endtask

  task automatic drive4(input logic e, input logic [5:0] v, input logic c);
    b4.en = e; b4.x = v; b4.clr = c;
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    b16.en = 1'b0; b4.en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b16.en = 1'b1; b16.x = 6'h3F; b16.clr = 1'b0;
    b4.en = 1'b1;  b4.x = 6'h3F;  b4.clr = 1'b0;
    tick();
    reset = 1'b0; b16.en = 1'b0; b4.en = 1'b0;
    checks++; if (b16.locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b want 0", b16.locked); end
    checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL reset_bit_err: got %0b want 0", b16.bit_err); end
    checks++; if (b16.err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt: got %0d want 0", b16.err_cnt); end
    checks++; if (b16.lockup !== 1'b0) begin failures++; $display("FAIL reset_lockup: got %0b want 0", b16.lockup); end
    checks++; if (b4.err_cnt !== 4'd0) begin failures++; $display("FAIL reset_err_cnt4: got %0d want 0", b4.err_cnt); end
  endtask

  // Seed + 4 matches locks; then stays locked on clean words.
  task automatic test_lock();
    logic exp_l;
    w = 6'h00;
    for (int i = 0; i < 9; i++) begin
      drive16(1'b1, w, 1'b0);
      w = nxt(w);
      exp_l = (i >= 4);
      checks++; if (b16.locked !== exp_l) begin failures++; $display("FAIL lock_locked_%0d: got %0b want %0b", i, b16.locked, exp_l); end
      checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL lock_bit_err_%0d: got %0b want 0", i, b16.bit_err); end
    end
    checks++; if (b16.err_cnt !== 16'd0) begin failures++; $display("FAIL lock_err_cnt: got %0d want 0", b16.err_cnt); end
  endtask

  task automatic test_flywheel();
    drive16(1'b1, w ^ 6'h03, 1'b0);
    w = nxt(w);
    checks++; if (b16.bit_err !== 1'b1) begin failures++; $display("FAIL fly_bit_err: got %0b want 1", b16.bit_err); end
    checks++; if (b16.err_cnt !== 16'd2) begin failures++; $display("FAIL fly_err_cnt: got %0d want 2", b16.err_cnt); end
    checks++; if (b16.locked !== 1'b1) begin failures++; $display("FAIL fly_locked: got %0b want 1", b16.locked); end
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1, w, 1'b0);
      w = nxt(w);
      checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL fly_clean_bit_err_%0d: got %0b want 0", i, b16.bit_err); end
      checks++; if (b16.err_cnt !== 16'd2) begin failures++; $display("FAIL fly_clean_err_cnt_%0d: got %0d want 2", i, b16.err_cnt); end
      checks++; if (b16.locked !== 1'b1) begin failures++; $display("FAIL fly_clean_locked_%0d: got %0b want 1", i, b16.locked); end
    end
  endtask

  // Three all-bits-wrong words: +6 each, lock lost on the third; relock after seed + 4.
  task automatic test_loss_relock();
    logic [15:0] exp_e;
    logic        exp_l;
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1, ~w, 1'b0);
      w = nxt(w);
      exp_e = 16'(2 + 6 * (i + 1));
      exp_l = (i < 2);
      checks++; if (b16.err_cnt !== exp_e) begin failures++; $display("FAIL loss_err_cnt_%0d: got %0d want %0d", i, b16.err_cnt, exp_e); end
      checks++; if (b16.locked !== exp_l) begin failures++; $display("FAIL loss_locked_%0d: got %0b want %0b", i, b16.locked, exp_l); end
      checks++; if (b16.bit_err !== 1'b1) begin failures++; $display("FAIL loss_bit_err_%0d: got %0b want 1", i, b16.bit_err); end
    end
    for (int i = 0; i < 5; i++) begin
      drive16(1'b1, w, 1'b0);
      w = nxt(w);
      exp_l = (i == 4);
      checks++; if (b16.locked !== exp_l) begin failures++; $display("FAIL relock_locked_%0d: got %0b want %0b", i, b16.locked, exp_l); end
      checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL relock_bit_err_%0d: got %0b want 0", i, b16.bit_err); end
      checks++; if (b16.err_cnt !== 16'd20) begin failures++; $display("FAIL relock_err_cnt_%0d: got %0d want 20", i, b16.err_cnt); end
    end
  endtask

  task automatic test_en_toggle();
    logic exp_l;
    pulse_reset();
    w = 6'h00;
    for (int i = 0; i < 5; i++) begin
      drive16(1'b1, w, 1'b0);
      w = nxt(w);
      exp_l = (i == 4);
      checks++; if (b16.locked !== exp_l) begin failures++; $display("FAIL en_locked_%0d: got %0b want %0b", i, b16.locked, exp_l); end
      drive16(1'b0, 6'h15, 1'b0);
      checks++; if (b16.locked !== exp_l) begin failures++; $display("FAIL en_idle_locked_%0d: got %0b want %0b", i, b16.locked, exp_l); end
      checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL en_idle_bit_err_%0d: got %0b want 0", i, b16.bit_err); end
    end
    drive16(1'b1, w ^ 6'h20, 1'b0);
    w = nxt(w);
    checks++; if (b16.bit_err !== 1'b1) begin failures++; $display("FAIL en_err_bit_err: got %0b want 1", b16.bit_err); end
    checks++; if (b16.err_cnt !== 16'd1) begin failures++; $display("FAIL en_err_err_cnt: got %0d want 1", b16.err_cnt); end
    drive16(1'b0, 6'h2A, 1'b0);
    checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL en_gap_bit_err: got %0b want 0", b16.bit_err); end
    checks++; if (b16.err_cnt !== 16'd1) begin failures++; $display("FAIL en_gap_err_cnt: got %0d want 1", b16.err_cnt); end
    checks++; if (b16.locked !== 1'b1) begin failures++; $display("FAIL en_gap_locked: got %0b want 1", b16.locked); end
    drive16(1'b1, w, 1'b0);
    w = nxt(w);
    checks++; if (b16.bit_err !== 1'b0) begin failures++; $display("FAIL en_resume_bit_err: got %0b want 0", b16.bit_err); end
    checks++; if (b16.err_cnt !== 16'd1) begin failures++; $display("FAIL en_resume_err_cnt: got %0d want 1", b16.err_cnt); end
  endtask

  // Entered locked with err_cnt=1.
  task automatic test_clr_reset();
    logic exp_l;
    drive16(1'b1, w ^ 6'h0C, 1'b1);
    w = nxt(w);
    checks++; if (b16.err_cnt !== 16'd0) begin failures++; $display("FAIL clr_err_cnt: got %0d want 0", b16.err_cnt); end
    checks++; if (b16.bit_err !== 1'b1) begin failures++; $display("FAIL clr_bit_err: got %0b want 1", b16.bit_err); end
    checks++; if (b16.locked !== 1'b1) begin failures++; $display("FAIL clr_locked: got %0b want 1", b16.locked); end
    reset = 1'b1;
    b16.en = 1'b1; b16.x = 6'h3F; b16.clr = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (b16.locked !== 1'b0) begin failures++; $display("FAIL rst_sync_locked: got %0b want 0", b16.locked); end
    checks++; if (b16.lockup !== 1'b0) begin failures++; $display("FAIL rst_sync_lockup: got %0b want 0", b16.lockup); end
    for (int i = 0; i < 5; i++) begin
      drive16(1'b1, w, 1'b0);
      w = nxt(w);
      exp_l = (i == 4);
      checks++; if (b16.locked !== exp_l) begin failures++; $display("FAIL rst_relock_%0d: got %0b want %0b", i, b16.locked, exp_l); end
    end
  endtask

  task automatic test_lockup();
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive16(1'b1, 6'h3F, 1'b0);
      checks++; if (b16.lockup !== 1'b1) begin failures++; $display("FAIL lockup_pulse_%0d: got %0b want 1", i, b16.lockup); end
      checks++; if (b16.locked !== 1'b0) begin failures++; $display("FAIL lockup_locked_%0d: got %0b want 0", i, b16.locked); end
    end
    drive16(1'b0, 6'h3F, 1'b0);
    checks++; if (b16.lockup !== 1'b0) begin failures++; $display("FAIL lockup_idle: got %0b want 0", b16.lockup); end
    drive16(1'b1, 6'h00, 1'b0);
    checks++; if (b16.lockup !== 1'b0) begin failures++; $display("FAIL lockup_clear: got %0b want 0", b16.lockup); end
  endtask

  task automatic test_saturation();
    logic [5:0] masks [7] = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h07, 6'h00, 6'h3F};
    logic [3:0] exps  [7] = '{4'd6, 4'd6, 4'd12, 4'd12, 4'd15, 4'd15, 4'd15};
    logic       exp_b;
    pulse_reset();
    b16.en = 1'b0;
    w = 6'h00;
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, w, 1'b0);
      w = nxt(w);
    end
    checks++; if (b4.locked !== 1'b1) begin failures++; $display("FAIL sat_locked: got %0b want 1", b4.locked); end
    for (int i = 0; i < 7; i++) begin
      drive4(1'b1, w ^ masks[i], 1'b0);
      w = nxt(w);
      exp_b = (masks[i] != 6'h00);
      checks++; if (b4.err_cnt !== exps[i]) begin failures++; $display("FAIL sat_err_cnt_%0d: got %0d want %0d", i, b4.err_cnt, exps[i]); end
      checks++; if (b4.bit_err !== exp_b) begin failures++; $display("FAIL sat_bit_err_%0d: got %0b want %0b", i, b4.bit_err, exp_b); end
      checks++; if (b4.locked !== 1'b1) begin failures++; $display("FAIL sat_locked_%0d: got %0b want 1", i, b4.locked); end
    end
    drive4(1'b0, 6'h00, 1'b1);
    checks++; if (b4.err_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr: got %0d want 0", b4.err_cnt); end
    checks++; if (b4.locked !== 1'b1) begin failures++; $display("FAIL sat_clr_locked: got %0b want 1", b4.locked); end
  endtask

  initial begin
    reset = 1'b1;
    b16.en = 1'b0; b16.x = 6'h00; b16.clr = 1'b0;
    b4.en = 1'b0;  b4.x = 6'h00;  b4.clr = 1'b0;
    test_reset();
    test_lock();
    test_flywheel();
    test_loss_relock();
    test_en_toggle();
    test_clr_reset();
    test_lockup();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
